// File: rtl/serial_adder.sv
// Bit-serial signed adder: one full-adder slice resolves one bit per clock.
// Optional subtract mode (A + ~B + 1) is enabled by defining ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [CW-1:0]    count;
  logic             c;
  logic             s, c_nxt, last, sub_sel;

  // Handshake: start is honoured only in IDLE; done is a one-cycle pulse
  // during which Sum/Cout/Ovf are already valid and then held.
`ifdef ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign s     = a_sr[0] ^ b_sr[0] ^ c;
  assign c_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
  assign last  = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      count  <= '0;
      c      <= 1'b0;
      Sum    <= '0;
      Cout   <= 1'b0;
      Ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= sub_sel ? ~B : B;
            c     <= sub_sel;
            count <= '0;
          end
        end
        RUN: begin
          c      <= c_nxt;
          sum_sr <= {s, sum_sr[WIDTH-1:1]};
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          count  <= count + CW'(1);
          // On the MSB slice the current c is the carry into the MSB.
          if (last) begin
            Sum  <= {s, sum_sr[WIDTH-1:1]};
            Cout <= c_nxt;
            Ovf  <= c ^ c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=16 instances,
// directed vectors with hand-computed results and done-cycle expectations.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-bit DUT
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       sub = 1'b0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
  logic [1:0] dbg_state;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
`ifdef ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .Sum(sum), .Cout(cout), .Ovf(ovf),
    .dbg_state(dbg_state)
  );

  // 16-bit DUT
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        sub16 = 1'b0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;
  logic [1:0]  dbg_state16;

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16),
`ifdef ADDER_SUB_EN
    .sub(sub16),
`endif
    .busy(busy16), .done(done16), .Sum(sum16), .Cout(cout16), .Ovf(ovf16),
    .dbg_state(dbg_state16)
  );

  // Scoreboard: {Sum, Cout, Ovf} and the cycle at which done is due
  logic [9:0]  exp_q[$];
  int          exp_cyc_q[$];
  logic [17:0] exp16_q[$];
  int          exp16_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor for the 8-bit DUT, including Sum hold between pulses
  logic [7:0] held_sum = '0;
  always @(negedge clk) begin
    if (rst) begin
      held_sum = '0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done8", 32'(done), 32'd0);
      end else begin
        logic [9:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result8", {22'd0, sum, cout, ovf}, {22'd0, e});
        check("done_cycle8", cyc, ec);
      end
      held_sum = sum;
    end else begin
      check("sum_hold8", {24'd0, sum}, {24'd0, held_sum});
    end
  end

  always @(negedge clk) begin
    if (!rst && done16) begin
      if (exp16_q.size() == 0) begin
        check("unexpected_done16", 32'(done16), 32'd0);
      end else begin
        logic [17:0] e;
        int ec;
        e  = exp16_q.pop_front();
        ec = exp16_cyc_q.pop_front();
        check("result16", {14'd0, sum16, cout16, ovf16}, {14'd0, e});
        check("done_cycle16", cyc, ec);
      end
    end
  end

  // Driver: wait for IDLE, present one start cycle, optionally log expectation
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       input logic do_push, input logic [9:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("idle_timeout", 32'(busy), 32'd0);
    start = 1'b1;
    a = ia;
    b = ib;
    sub = isub;
    if (do_push) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(cyc + 1 + 8);
    end
    @(negedge clk);
    start = 1'b0;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
  endtask

  initial begin
    int n;
    logic [7:0] sa[3];
    logic [7:0] sb[3];
    logic [9:0] se[3];

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_outs", {22'd0, sum, cout, ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 69+42: latency and busy length
    issue(8'd69, 8'd42, 1'b0, 1'b1, {8'd111, 1'b0, 1'b0});
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, 9);

    issue(8'd100, 8'd100, 1'b0, 1'b1, {8'hC8, 1'b0, 1'b1});
    issue(8'hFF,  8'd1,   1'b0, 1'b1, {8'h00, 1'b1, 1'b0});
    issue(8'h80,  8'h80,  1'b0, 1'b1, {8'h00, 1'b1, 1'b1});
    issue(8'd127, 8'd1,   1'b0, 1'b1, {8'h80, 1'b0, 1'b1});
    issue(8'hFF,  8'hFF,  1'b0, 1'b1, {8'hFE, 1'b1, 1'b0});
    issue(8'd0,   8'd0,   1'b0, 1'b1, {8'h00, 1'b0, 1'b0});

    // start held high: only operands present at the accepting edges count
    sa[0] = 8'd10;  sb[0] = 8'd20;  se[0] = {8'd30, 1'b0, 1'b0};
    sa[1] = 8'hCE;  sb[1] = 8'h9C;  se[1] = {8'h6A, 1'b1, 1'b1};
    sa[2] = 8'd127; sb[2] = 8'd127; se[2] = {8'hFE, 1'b0, 1'b1};
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    start = 1'b1;
    sub = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i % 10 == 0) begin
        a = sa[i / 10];
        b = sb[i / 10];
        exp_q.push_back(se[i / 10]);
        exp_cyc_q.push_back(cyc + 1 + 8);
      end else begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
      end
      @(negedge clk);
    end
    start = 1'b0;

    // Abort mid-RUN with an asynchronous reset
    issue(8'd69, 8'd42, 1'b0, 1'b0, '0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_outs", {22'd0, sum, cout, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'd69, 8'd42, 1'b0, 1'b1, {8'd111, 1'b0, 1'b0});

`ifdef ADDER_SUB_EN
    issue(8'd42,  8'd69,  1'b1, 1'b1, {8'hE5, 1'b0, 1'b0});
    issue(8'd0,   8'd127, 1'b1, 1'b1, {8'h81, 1'b0, 1'b0});
    issue(8'd69,  8'd42,  1'b1, 1'b1, {8'h1B, 1'b1, 1'b0});
    issue(8'h80,  8'd1,   1'b1, 1'b1, {8'h7F, 1'b1, 1'b1});
`endif

    // 16-bit instance: 30000 + 10000 wraps to -25536
    @(negedge clk);
    n = 0;
    while (busy16 && n < 100) begin
      n++;
      @(negedge clk);
    end
    start16 = 1'b1;
    a16 = 16'd30000;
    b16 = 16'd10000;
    sub16 = 1'b0;
    exp16_q.push_back({16'h9C40, 1'b0, 1'b1});
    exp16_cyc_q.push_back(cyc + 1 + 16);
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'h1234;
    b16 = 16'h4321;

    // Drain
    n = 0;
    while ((exp_q.size() != 0 || exp16_q.size() != 0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain_pending8", exp_q.size(), 0);
    check("drain_pending16", exp16_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
